// File: rtl/imem_load_fetch_ctrl_if.sv
// Loader, fetch and memory-port bundle of imem_load_fetch_ctrl.
// master = requester/memory side, slave = the controller.
interface imem_load_fetch_ctrl_if #(
  parameter int AW = 10
);
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          fetch_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output ld_valid, ld_data,
    output fetch_req, fetch_addr,
    output mem_rdata,
    input  ld_ready,
    input  fetch_ready, fetch_valid,
    input  fetch_data, fetch_err,
    input  mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  ld_valid, ld_data,
    input  fetch_req, fetch_addr,
    input  mem_rdata,
    output ld_ready,
    output fetch_ready, fetch_valid,
    output fetch_data, fetch_err,
    output mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_load_fetch_ctrl.sv
// Boot loader / fetch arbiter for the byte-wide instruction memory.
// Define IMEM_LOAD_CHECKSUM_EN to add load_csum / load_err checking.
module imem_load_fetch_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [AW:0] load_len,
`ifdef IMEM_LOAD_CHECKSUM_EN
  input  logic [7:0]  load_csum,
  output logic        load_err,
`endif
  output logic        load_done,
  output logic        core_rst_n,
  imem_load_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  localparam logic [AW:0]  DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [31:0]  LIMIT   = 32'(DEPTH - 3);
  localparam logic [31:0]  NOP     = 32'h0000_0013;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic          done_q, done_d;
  logic          fv_q, fv_d;
  logic          ferr_q, ferr_d;
  logic [31:0]   fdata_q, fdata_d;
  logic [AW:0]   clamp;
  logic          bad_addr;
  logic          ld_rdy;
  logic          we;
  logic          f_rdy;
  logic [AW-1:0] addr;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
  logic          lerr_q, lerr_d;
  logic [7:0]    sum;
`endif

  assign clamp    = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign bad_addr = (bus.fetch_addr[1:0] != 2'b00) ||
                    (bus.fetch_addr >= LIMIT);
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign sum      = csum_q + bus.ld_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = 1'b0;
    fv_d    = 1'b0;
    ferr_d  = ferr_q;
    fdata_d = fdata_q;
    ld_rdy  = 1'b0;
    we      = 1'b0;
    f_rdy   = 1'b0;
    addr    = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_d  = csum_q;
    lerr_d  = lerr_q;
`endif
    unique case (state_q)
      IDLE: ;
      LOAD: begin
        ld_rdy = !load_start;
        addr   = cnt_q;
        we     = bus.ld_valid && ld_rdy;
        if (we) begin
          cnt_d = cnt_q + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_d = sum;
`endif
          if ({1'b0, cnt_q} == len_q - 1'b1) begin
            done_d  = 1'b1;
            state_d = RUN;
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (sum != 8'h00) begin
              lerr_d  = 1'b1;
              state_d = IDLE;
            end
`endif
          end
        end
      end
      RUN: begin
        f_rdy = bus.fetch_req && !fv_q;
        addr  = bus.fetch_addr[AW-1:0];
        if (f_rdy) begin
          fv_d    = 1'b1;
          ferr_d  = bad_addr;
          fdata_d = bad_addr ? NOP : bus.mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fetch accepted this cycle still completes in the first LOAD cycle.
    if (load_start) begin
      cnt_d   = '0;
      len_d   = clamp;
      state_d = LOAD;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_d  = load_csum;
      lerr_d  = 1'b0;
`endif
      if (clamp == '0) begin
        done_d  = 1'b1;
        state_d = RUN;
`ifdef IMEM_LOAD_CHECKSUM_EN
        if (load_csum != 8'h00) begin
          lerr_d  = 1'b1;
          state_d = IDLE;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      ferr_q  <= 1'b0;
      fdata_q <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q  <= '0;
      lerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      done_q  <= done_d;
      fv_q    <= fv_d;
      ferr_q  <= ferr_d;
      fdata_q <= fdata_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_q  <= csum_d;
      lerr_q  <= lerr_d;
`endif
    end
  end

  assign bus.ld_ready    = ld_rdy;
  assign bus.mem_we      = we;
  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = bus.ld_data;
  assign bus.fetch_ready = f_rdy;
  assign bus.fetch_valid = fv_q;
  assign bus.fetch_err   = ferr_q;
  assign bus.fetch_data  = fdata_q;
  assign load_done       = done_q;
  assign core_rst_n      = (state_q == RUN);
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign load_err        = lerr_q;
`endif

endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Directed bench for imem_load_fetch_ctrl with a byte-array memory model.
// Fetch vectors are table-driven; load corner cases are hand sequences.
module tb_imem_load_fetch_ctrl;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } fvec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    load_csum;
  logic          load_done;
  logic          core_rst_n;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic          load_err;
`endif

  imem_load_fetch_ctrl_if #(.AW(AW)) bus ();

  imem_load_fetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .load_csum  (load_csum),
    .load_err   (load_err),
`endif
    .load_done  (load_done),
    .core_rst_n (core_rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    mem [DEPTH];
  logic          mem_init;
  logic [AW-1:0] a1, a2, a3;
  assign a1 = bus.mem_addr + 6'd1;
  assign a2 = bus.mem_addr + 6'd2;
  assign a3 = bus.mem_addr + 6'd3;
  assign bus.mem_rdata = {mem[a3], mem[a2], mem[a1], mem[bus.mem_addr]};

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  logic [AW-1:0] wa [$];
  logic [7:0]    wd [$];
  int            bad_we   = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    #3;
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
      if (!bus.ld_valid) bad_we++;
    end
    if (load_done) done_cnt++;
  end

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] ld_bytes [8];
  fvec_t      fv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_load(input int n, input logic [7:0] cs,
                         input bit gap, input bit exp_run);
    int  i = 0;
    int  g = 0;
    bit  tog = 1'b0;
    bit  acc;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = (AW+1)'(n);
    load_csum  = cs;
    @(negedge clk);
    load_start = 1'b0;
    while (i < n && g < 100) begin
      tog          = !tog;
      bus.ld_valid = gap ? tog : 1'b1;
      bus.ld_data  = ld_bytes[i];
      #1;
      acc = bus.ld_valid && bus.ld_ready;
      @(negedge clk);
      if (acc) i++;
      g++;
    end
    bus.ld_valid = 1'b0;
    if (g >= 100) chk("load timeout", 32'(i), 32'(n));
    #1;
    chk("load_done pulse", 32'(load_done), 1);
    chk("core_rst_n after load", 32'(core_rst_n), 32'(exp_run));
    @(negedge clk);
    #1;
    chk("load_done one cycle", 32'(load_done), 0);
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] a,
                          input logic [31:0] ed, input logic ee);
    int g = 0;
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    #1;
    while (!bus.fetch_ready && g < 10) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk({nm, " ready"}, 32'(bus.fetch_ready), 1);
    chk({nm, " no early valid"}, 32'(bus.fetch_valid), 0);
    @(negedge clk);
    #1;
    chk({nm, " valid"}, 32'(bus.fetch_valid), 1);
    chk({nm, " data"}, bus.fetch_data, ed);
    chk({nm, " err"}, 32'(bus.fetch_err), 32'(ee));
    chk({nm, " busy"}, 32'(bus.fetch_ready), 0);
    bus.fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    fv[0] = '{"f0",    32'd0,   32'h00C0_0093, 1'b0};
    fv[1] = '{"f4",    32'd4,   32'h0100_0113, 1'b0};
    fv[2] = '{"f6",    32'd6,   32'h0000_0013, 1'b1};
    fv[3] = '{"fD-4",  32'd60,  32'h9A9B_9899, 1'b0};
    fv[4] = '{"fD",    32'd64,  32'h0000_0013, 1'b1};
    fv[5] = '{"fD-3",  32'd61,  32'h0000_0013, 1'b1};
    fv[6] = '{"f56",   32'd56,  32'h9E9F_9C9D, 1'b0};
    fv[7] = '{"f256",  32'd256, 32'h0000_0013, 1'b1};

    rst_n          = 1'b0;
    mem_init       = 1'b0;
    load_start     = 1'b0;
    load_len       = '0;
    load_csum      = '0;
    bus.ld_valid   = 1'b1;
    bus.ld_data    = 8'h5A;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    repeat (3) @(negedge clk);
    mem_init = 1'b1;
    rst_n    = 1'b1;
    #1;
    chk("rst ld_ready", 32'(bus.ld_ready), 0);
    chk("rst mem_we", 32'(bus.mem_we), 0);
    chk("rst fetch_ready", 32'(bus.fetch_ready), 0);
    chk("rst fetch_valid", 32'(bus.fetch_valid), 0);
    chk("rst fetch_err", 32'(bus.fetch_err), 0);
    chk("rst fetch_data", bus.fetch_data, 0);
    chk("rst mem_addr", 32'(bus.mem_addr), 0);
    chk("rst load_done", 32'(load_done), 0);
    chk("rst core_rst_n", 32'(core_rst_n), 0);
    @(negedge clk);
    #1;
    chk("idle no write", 32'(wa.size()), 0);
    bus.ld_valid  = 1'b0;
    bus.fetch_req = 1'b0;

    ld_bytes = '{8'h93, 8'h00, 8'hC0, 8'h00, 8'h13, 8'h01, 8'h00, 8'h01};
    do_load(8, 8'h00, 1'b0, 1'b1);
    chk("t1 writes", 32'(wa.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1 waddr", 32'(wa[i]), 32'(i));
      chk("t1 wdata", 32'(wd[i]), 32'(ld_bytes[i]));
    end
    chk("t1 done count", 32'(done_cnt), 1);

    for (int i = 0; i < 8; i++)
      do_fetch(fv[i].name, fv[i].addr, fv[i].data, fv[i].err);

    n0 = wa.size();
    ld_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0};
    do_load(4, 8'h00, 1'b1, 1'b1);
    chk("t3 writes", 32'(wa.size()), 32'(n0 + 4));
    for (int i = 0; i < 4; i++) begin
      chk("t3 waddr", 32'(wa[n0+i]), 32'(i));
      chk("t3 wdata", 32'(wd[n0+i]), 32'(ld_bytes[i]));
    end
    chk("t3 gap writes", 32'(bad_we), 0);
    chk("t3 done count", 32'(done_cnt), 2);
    do_fetch("t3 f0", 32'd0, 32'h4433_2211, 1'b0);

    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 32'd4;
    load_start     = 1'b1;
    load_len       = 7'd2;
    #1;
    chk("t4 ready", 32'(bus.fetch_ready), 1);
    @(negedge clk);
    load_start    = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    chk("t4 valid", 32'(bus.fetch_valid), 1);
    chk("t4 data", bus.fetch_data, 32'h0100_0113);
    chk("t4 core rst", 32'(core_rst_n), 0);
    chk("t4 ld_ready", 32'(bus.ld_ready), 1);
    n0 = wa.size();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'hAA;
    @(negedge clk);
    bus.ld_data  = 8'hBB;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1;
    chk("t4 done", 32'(load_done), 1);
    chk("t4 run", 32'(core_rst_n), 1);
    #5;
    chk("t4 writes", 32'(wa.size()), 32'(n0 + 2));
    chk("t4 waddr0", 32'(wa[n0]), 0);
    chk("t4 wdata0", 32'(wd[n0]), 32'h0AA);
    chk("t4 waddr1", 32'(wa[n0+1]), 1);
    n0 = wa.size();
    do_load(0, 8'h00, 1'b0, 1'b1);
    chk("t4 len0 no write", 32'(wa.size()), 32'(n0));

    @(negedge clk);
    load_start = 1'b1;
    load_len   = 7'd8;
    @(negedge clk);
    load_start   = 1'b0;
    n0           = wa.size();
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_data = 8'(8'h60 + i);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 ld_ready", 32'(bus.ld_ready), 0);
    chk("t5 mem_we", 32'(bus.mem_we), 0);
    chk("t5 mem_addr", 32'(bus.mem_addr), 0);
    chk("t5 core rst", 32'(core_rst_n), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("t5 ignored ld_ready", 32'(bus.ld_ready), 0);
    #5;
    chk("t5 writes", 32'(wa.size()), 32'(n0 + 3));
    bus.ld_valid = 1'b0;

`ifdef IMEM_LOAD_CHECKSUM_EN
    ld_bytes = '{8'h01, 8'h02, 8'h03, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    do_load(3, 8'hFA, 1'b0, 1'b1);
    chk("t6 good err", 32'(load_err), 0);
    do_load(3, 8'hFB, 1'b0, 1'b0);
    chk("t6 bad err", 32'(load_err), 1);
    @(negedge clk);
    bus.fetch_req = 1'b1;
    #1;
    chk("t6 idle core rst", 32'(core_rst_n), 0);
    chk("t6 idle refuse", 32'(bus.fetch_ready), 0);
    chk("t6 err sticky", 32'(load_err), 1);
    bus.fetch_req = 1'b0;
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
